rl_lj_pair_scheduler: RTL and testbench

- Sequences particle-pair reads for one home cell against NUM_NEIGHBOR_CELLS cells. Cell 0 is the home cell itself.
- Generates home/neighbor RAM read addresses and a neighbor-cell select.
- Stalls cleanly on filter back-pressure, drains the force pipeline, then pulses done.
- Sits between the cell position RAMs and the force evaluation unit with its filter bank.

---
 rtl/rl_lj_pair_scheduler_pkg.sv | 32 +++
 rtl/rl_lj_pair_scheduler_if.sv | 36 +++
 rtl/rl_lj_pair_counter.sv | 74 +++++++
 rtl/rl_lj_pair_scheduler.sv | 138 +++++++++++++
 tb/tb_rl_lj_pair_scheduler.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rl_lj_pair_scheduler_pkg.sv
// Shared state encoding and default sizing for the LJ pair scheduler.
// RL_LJ_HOME_HALF_PAIR_EN: the home cell issues only pairs with n > h.
package rl_lj_sched_pkg;

  typedef enum logic [2:0] {
    WAIT_FOR_START = 3'd0,
    LOAD           = 3'd1,
    ISSUE          = 3'd2,
    DRAIN          = 3'd3,
    DONE           = 3'd4
  } sched_state_e;

  localparam int DEF_PARTICLE_ID_WIDTH  = 20;
  localparam int DEF_ADDR_WIDTH         = 7;
  localparam int DEF_NUM_NEIGHBOR_CELLS = 14;
  localparam int DEF_CELL_SEL_WIDTH     = 4;
  localparam int DEF_NUM_FILTER         = 4;
  localparam int DEF_DRAIN_CYCLES       = 31;
  localparam int DEF_DRAIN_CNT_WIDTH    = 6;

`ifdef RL_LJ_HOME_HALF_PAIR_EN
  localparam bit HOME_HALF_PAIR = 1'b1;
`else
  localparam bit HOME_HALF_PAIR = 1'b0;
`endif

  // Counts carry one extra bit so a full 2^ADDR_WIDTH cell is representable.
  function automatic int cnt_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/rl_lj_pair_scheduler_if.sv
// Request/count/back-pressure inputs and RAM-read/pair outputs of the scheduler.
interface rl_lj_pair_scheduler_if
  import rl_lj_sched_pkg::*;
#(
  parameter int PARTICLE_ID_WIDTH  = DEF_PARTICLE_ID_WIDTH,
  parameter int ADDR_WIDTH         = DEF_ADDR_WIDTH,
  parameter int NUM_NEIGHBOR_CELLS = DEF_NUM_NEIGHBOR_CELLS,
  parameter int CELL_SEL_WIDTH     = DEF_CELL_SEL_WIDTH,
  parameter int NUM_FILTER         = DEF_NUM_FILTER
);
  logic                                        start;
  logic [ADDR_WIDTH:0]                         home_particle_num;
  logic [NUM_NEIGHBOR_CELLS*(ADDR_WIDTH+1)-1:0] neighbor_particle_num;
  logic [NUM_FILTER-1:0]                       back_pressure;
  logic                                        rden;
  logic [ADDR_WIDTH-1:0]                       home_rdaddr;
  logic [CELL_SEL_WIDTH-1:0]                   neighbor_cell_sel;
  logic [ADDR_WIDTH-1:0]                       neighbor_rdaddr;
  logic                                        pair_valid;
  logic [PARTICLE_ID_WIDTH-1:0]                ref_particle_id;
  logic [PARTICLE_ID_WIDTH-1:0]                neighbor_particle_id;
  logic                                        busy;
  logic                                        done;

  modport master (
    output start, home_particle_num, neighbor_particle_num, back_pressure,
    input  rden, home_rdaddr, neighbor_cell_sel, neighbor_rdaddr,
           pair_valid, ref_particle_id, neighbor_particle_id, busy, done
  );

  modport slave (
    input  start, home_particle_num, neighbor_particle_num, back_pressure,
    output rden, home_rdaddr, neighbor_cell_sel, neighbor_rdaddr,
           pair_valid, ref_particle_id, neighbor_particle_id, busy, done
  );
endinterface

// File: rtl/rl_lj_pair_counter.sv
// Nested home(h) / cell(c) / neighbor(n) sweep pointer; advance_i takes one step.
// cell_empty_o marks a bubble step, last_o marks the step that finishes the sweep.
module rl_lj_pair_counter
  import rl_lj_sched_pkg::*;
#(
  parameter int ADDR_WIDTH         = DEF_ADDR_WIDTH,
  parameter int NUM_NEIGHBOR_CELLS = DEF_NUM_NEIGHBOR_CELLS,
  parameter int CELL_SEL_WIDTH     = DEF_CELL_SEL_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear_i,
  input  logic                      advance_i,
  input  logic [ADDR_WIDTH:0]       home_limit_i,
  input  logic [ADDR_WIDTH:0]       cell_limit_i,
  output logic [ADDR_WIDTH-1:0]     h_o,
  output logic [CELL_SEL_WIDTH-1:0] c_o,
  output logic [ADDR_WIDTH-1:0]     n_o,
  output logic                      cell_empty_o,
  output logic                      last_o
);
  localparam int CNT_W = cnt_width(ADDR_WIDTH);

  logic [CNT_W-1:0]          h_q, h_d, n_q, n_d;
  logic [CELL_SEL_WIDTH-1:0] c_q, c_d;
  logic [CNT_W-1:0]          h_nxt, n_nxt;
  logic                      cell_end, c_last;

  assign h_nxt    = h_q + 1'b1;
  assign n_nxt    = n_q + 1'b1;
  // n starts past the limit for an empty cell, so one compare covers both cases.
  assign cell_end = (n_nxt >= cell_limit_i);
  assign c_last   = (c_q == CELL_SEL_WIDTH'(NUM_NEIGHBOR_CELLS - 1));

  assign cell_empty_o = (n_q >= cell_limit_i);
  assign last_o       = cell_end && c_last && (h_nxt == home_limit_i);
  assign h_o          = h_q[ADDR_WIDTH-1:0];
  assign c_o          = c_q;
  assign n_o          = n_q[ADDR_WIDTH-1:0];

  always_comb begin
    h_d = h_q;
    c_d = c_q;
    n_d = n_q;
    if (clear_i) begin
      h_d = '0;
      c_d = '0;
      n_d = HOME_HALF_PAIR ? CNT_W'(1) : '0;
    end else if (advance_i) begin
      if (!cell_end) begin
        n_d = n_nxt;
      end else if (!c_last) begin
        c_d = c_q + 1'b1;
        n_d = '0;
      end else begin
        c_d = '0;
        h_d = h_nxt;
        n_d = HOME_HALF_PAIR ? (h_nxt + 1'b1) : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q <= '0;
      c_q <= '0;
      n_q <= '0;
    end else begin
      h_q <= h_d;
      c_q <= c_d;
      n_q <= n_d;
    end
  end
endmodule

// File: rtl/rl_lj_pair_scheduler.sv
// Sweeps home-cell particles against all neighbor cells, driving RAM reads and
// pair IDs; stalls on any back-pressure bit, drains, then pulses done.
module rl_lj_pair_scheduler
  import rl_lj_sched_pkg::*;
#(
  parameter int PARTICLE_ID_WIDTH  = DEF_PARTICLE_ID_WIDTH,
  parameter int ADDR_WIDTH         = DEF_ADDR_WIDTH,
  parameter int NUM_NEIGHBOR_CELLS = DEF_NUM_NEIGHBOR_CELLS,
  parameter int CELL_SEL_WIDTH     = DEF_CELL_SEL_WIDTH,
  parameter int NUM_FILTER         = DEF_NUM_FILTER,
  parameter int DRAIN_CYCLES       = DEF_DRAIN_CYCLES,
  parameter int DRAIN_CNT_WIDTH    = DEF_DRAIN_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  rl_lj_pair_scheduler_if.slave bus
);
  localparam int CNT_W = cnt_width(ADDR_WIDTH);

  sched_state_e               state_q, state_d;
  logic [DRAIN_CNT_WIDTH-1:0] drain_q, drain_d;
  logic [CNT_W-1:0]           home_cnt_q;
  logic [CNT_W-1:0]           cell_cnt_q [NUM_NEIGHBOR_CELLS];
  logic [NUM_FILTER-1:0]      bp;
  logic                       step, issue, drain_last, busy_c, done_c;
  logic [ADDR_WIDTH-1:0]      ptr_h, ptr_n;
  logic [CELL_SEL_WIDTH-1:0]  ptr_c;
  logic                       cell_empty, ptr_last;

  logic                         rden_q, pair_valid_q;
  logic [ADDR_WIDTH-1:0]        home_rdaddr_q, neighbor_rdaddr_q;
  logic [CELL_SEL_WIDTH-1:0]    cell_sel_q;
  logic [PARTICLE_ID_WIDTH-1:0] ref_id_q, nbr_id_q;

  assign bp         = bus.back_pressure;
  // Back-pressure freezes bubbles too, so the pointer moves only when bp is clear.
  assign step       = (state_q == ISSUE) && (bp == '0);
  assign issue      = step && !cell_empty;
  assign drain_last = (drain_q == DRAIN_CNT_WIDTH'(DRAIN_CYCLES - 1));

  rl_lj_pair_counter #(
    .ADDR_WIDTH        (ADDR_WIDTH),
    .NUM_NEIGHBOR_CELLS(NUM_NEIGHBOR_CELLS),
    .CELL_SEL_WIDTH    (CELL_SEL_WIDTH)
  ) u_counter (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (state_q == LOAD),
    .advance_i   (step),
    .home_limit_i(home_cnt_q),
    .cell_limit_i(cell_cnt_q[ptr_c]),
    .h_o         (ptr_h),
    .c_o         (ptr_c),
    .n_o         (ptr_n),
    .cell_empty_o(cell_empty),
    .last_o      (ptr_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT_FOR_START;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d = state_q;
    drain_d = '0;
    case (state_q)
      WAIT_FOR_START: if (bus.start) state_d = LOAD;
      LOAD:           state_d = (bus.home_particle_num == '0) ? DONE : ISSUE;
      ISSUE:          if (step && ptr_last) state_d = DRAIN;
      DRAIN: begin
        if (drain_last) state_d = DONE;
        else            drain_d = drain_q + 1'b1;
      end
      DONE:           state_d = WAIT_FOR_START;
      default:        state_d = WAIT_FOR_START;
    endcase
  end

  always_comb begin
    busy_c = 1'b0;
    done_c = 1'b0;
    case (state_q)
      LOAD, ISSUE, DRAIN: busy_c = 1'b1;
      DONE:               done_c = 1'b1;
      default:            ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      home_cnt_q <= '0;
      for (int k = 0; k < NUM_NEIGHBOR_CELLS; k++) cell_cnt_q[k] <= '0;
    end else if (state_q == LOAD) begin
      home_cnt_q <= bus.home_particle_num;
      for (int k = 0; k < NUM_NEIGHBOR_CELLS; k++)
        cell_cnt_q[k] <= bus.neighbor_particle_num[k*CNT_W +: CNT_W];
    end
  end

  // Addresses hold across stalls and bubbles; IDs are zero unless a read was issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      rden_q            <= 1'b0;
      home_rdaddr_q     <= '0;
      cell_sel_q        <= '0;
      neighbor_rdaddr_q <= '0;
      pair_valid_q      <= 1'b0;
      ref_id_q          <= '0;
      nbr_id_q          <= '0;
    end else begin
      rden_q <= issue;
      if (issue) begin
        home_rdaddr_q     <= ptr_h;
        cell_sel_q        <= ptr_c;
        neighbor_rdaddr_q <= ptr_n;
      end
      pair_valid_q <= rden_q;
      ref_id_q     <= rden_q ? PARTICLE_ID_WIDTH'(home_rdaddr_q) : '0;
      nbr_id_q     <= rden_q ? PARTICLE_ID_WIDTH'({cell_sel_q, neighbor_rdaddr_q}) : '0;
    end
  end

  assign bus.rden                 = rden_q;
  assign bus.home_rdaddr          = home_rdaddr_q;
  assign bus.neighbor_cell_sel    = cell_sel_q;
  assign bus.neighbor_rdaddr      = neighbor_rdaddr_q;
  assign bus.pair_valid           = pair_valid_q;
  assign bus.ref_particle_id      = ref_id_q;
  assign bus.neighbor_particle_id = nbr_id_q;
  assign bus.busy                 = busy_c;
  assign bus.done                 = done_c;
endmodule

// File: tb/tb_rl_lj_pair_scheduler.sv
// Directed bench for rl_lj_pair_scheduler: pair order, bubbles, stall, drain timing, reset abort.
module tb_rl_lj_pair_scheduler;
  localparam int NC = 14;
  localparam int CW = 8;
`ifdef RL_LJ_HOME_HALF_PAIR_EN
  localparam int T1_N = 81;
  localparam int T2_N = 2;
  localparam int T6_N = 6;
`else
  localparam int T1_N = 84;
  localparam int T2_N = 3;
  localparam int T6_N = 16;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rl_lj_pair_scheduler_if bus ();
  rl_lj_pair_scheduler dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   got_q[$];
  int   rcyc_q[$];
  int   exp_q[$];
  int   pv_cnt, pv_bad, id_bad, done_cnt, done_cyc, start_cyc;
  logic prev_rden = 1'b0;
  int   prev_ref = 0, prev_nbr = 0;

  always @(negedge clk) begin
    if (bus.pair_valid !== prev_rden) pv_bad++;
    if (int'(bus.ref_particle_id) != (prev_rden ? prev_ref : 0)) id_bad++;
    if (int'(bus.neighbor_particle_id) != (prev_rden ? prev_nbr : 0)) id_bad++;
    if (bus.pair_valid === 1'b1) pv_cnt++;
    if (bus.rden === 1'b1) begin
      got_q.push_back(int'(bus.home_rdaddr) * 2048 + int'(bus.neighbor_cell_sel) * 128 +
                      int'(bus.neighbor_rdaddr));
      rcyc_q.push_back(cyc);
    end
    if (bus.done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    prev_rden = rst ? 1'b0 : bus.rden;
    prev_ref  = int'(bus.home_rdaddr);
    prev_nbr  = int'({bus.neighbor_cell_sel, bus.neighbor_rdaddr});
  end

  task automatic clear_mon();
    got_q.delete();
    rcyc_q.delete();
    pv_cnt = 0; pv_bad = 0; id_bad = 0; done_cnt = 0; done_cyc = 0;
  endtask

  task automatic build_exp(input int home, input int cnt[NC]);
    exp_q.delete();
    for (int h = 0; h < home; h++)
      for (int c = 0; c < NC; c++) begin
        int s;
        s = 0;
`ifdef RL_LJ_HOME_HALF_PAIR_EN
        if (c == 0) s = h + 1;
`endif
        for (int n = s; n < cnt[c]; n++) exp_q.push_back(h * 2048 + c * 128 + n);
      end
  endtask

  task automatic start_pulse(input int home, input int cnt[NC]);
    bus.home_particle_num = CW'(home);
    for (int k = 0; k < NC; k++) bus.neighbor_particle_num[k*CW +: CW] = CW'(cnt[k]);
    @(posedge clk); #1;
    bus.start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic run_sweep(input int home, input int cnt[NC], input int bp_at, input int bp_len);
    int i;
    clear_mon();
    build_exp(home, cnt);
    start_pulse(home, cnt);
    i = 0;
    while (done_cnt == 0 && i < 3000) begin
      @(posedge clk); #1;
      if (bp_len > 0 && i == bp_at) bus.back_pressure = 4'b0010;
      if (i == bp_at + bp_len) bus.back_pressure = '0;
      i++;
    end
    if (done_cnt == 0) check_eq("sweep_timeout", 0, 1);
    bus.back_pressure = '0;
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic cmp_seq(input string tag);
    int first_bad;
    first_bad = -1;
    check_eq({tag, "_npairs_model"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (first_bad < 0 && got_q[i] != exp_q[i]) first_bad = i;
    check_eq({tag, "_order_first_bad"}, first_bad, -1);
    check_eq({tag, "_pv_vs_rden"}, pv_bad, 0);
    check_eq({tag, "_ids"}, id_bad, 0);
    check_eq({tag, "_done_once"}, done_cnt, 1);
  endtask

  function automatic int last_gap();
    if (rcyc_q.size() < 2) return -1;
    return rcyc_q[rcyc_q.size()-1] - rcyc_q[rcyc_q.size()-2];
  endfunction

  function automatic int done_gap();
    if (rcyc_q.size() == 0) return -1;
    return done_cyc - rcyc_q[rcyc_q.size()-1];
  endfunction

  function automatic int outs_or();
    return int'(|{bus.rden, bus.home_rdaddr, bus.neighbor_cell_sel, bus.neighbor_rdaddr,
                  bus.pair_valid, bus.ref_particle_id, bus.neighbor_particle_id,
                  bus.busy, bus.done});
  endfunction

  int c3[NC];
  int c2[NC];
  int c1[NC];
  int c4[NC];
  int cz[NC];
  int span, maxgap, cell0, gt_h;

  initial begin
    for (int k = 0; k < NC; k++) begin
      c3[k] = 3; c2[k] = 0; c1[k] = 0; c4[k] = 0; cz[k] = 0;
    end
    c2[0] = 2; c2[13] = 1;
    c1[0] = 1;
    c4[0] = 4;

    bus.start = 1'b0;
    bus.back_pressure = '0;
    bus.home_particle_num = '0;
    bus.neighbor_particle_num = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_outputs_zero", outs_or(), 0);
    rst = 1'b0;
    clear_mon();

    // Full sweep, 2 home x 14 cells x 3.
    run_sweep(2, c3, 0, 0);
    cmp_seq("t1");
    check_eq("t1_npairs", got_q.size(), T1_N);
    check_eq("t1_pair_valid_cnt", pv_cnt, T1_N);
    check_eq("t1_done_after_drain", done_gap(), 31);
    check_eq("t1_span", rcyc_q[$] - rcyc_q[0], T1_N - 1);

    // Cells {2,0..0,1}: 12 empty-cell bubbles before the final pair.
    run_sweep(1, c2, 0, 0);
    cmp_seq("t2");
    check_eq("t2_npairs", got_q.size(), T2_N);
    check_eq("t2_bubble_gap", last_gap(), 13);
    check_eq("t2_done_after_drain", done_gap(), 31);

    // 5-cycle stall mid-sweep.
    run_sweep(2, c3, 20, 5);
    cmp_seq("t3");
    span = rcyc_q[$] - rcyc_q[0];
    maxgap = 0;
    for (int i = 1; i < rcyc_q.size(); i++)
      if (rcyc_q[i] - rcyc_q[i-1] > maxgap) maxgap = rcyc_q[i] - rcyc_q[i-1];
    check_eq("t3_span_with_stall", span, T1_N - 1 + 5);
    check_eq("t3_stall_gap", maxgap, 6);

    // Empty home cell.
    run_sweep(0, c3, 0, 0);
    check_eq("t4_npairs", got_q.size(), 0);
    check_eq("t4_done_latency", done_cyc - start_cyc, 2);
    check_eq("t4_done_once", done_cnt, 1);

    // Reset during ISSUE.
    clear_mon();
    start_pulse(2, c3);
    repeat (20) @(posedge clk);
    #1;
    check_eq("t5_issue_rden", int'(bus.rden), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("t5_issue_rst_outputs", outs_or(), 0);
    rst = 1'b0;
    repeat (120) @(posedge clk);
    #1;
    check_eq("t5_issue_no_done", done_cnt, 0);

    // Reset during DRAIN.
    clear_mon();
    start_pulse(1, c1);
    repeat (25) @(posedge clk);
    #1;
    check_eq("t5_drain_busy", int'(bus.busy), 1);
    check_eq("t5_drain_rden", int'(bus.rden), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("t5_drain_rst_outputs", outs_or(), 0);
    rst = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    check_eq("t5_drain_no_done", done_cnt, 0);

    run_sweep(2, c3, 0, 0);
    cmp_seq("t5_resweep");
    check_eq("t5_resweep_npairs", got_q.size(), T1_N);

    // Home cell only, count 4.
    run_sweep(4, c4, 0, 0);
    cmp_seq("t6");
    cell0 = 0;
    gt_h = 0;
    foreach (got_q[i]) begin
      if (((got_q[i] / 128) % 16) == 0) begin
        cell0++;
        if ((got_q[i] % 128) > (got_q[i] / 2048)) gt_h++;
      end
    end
    check_eq("t6_cell0_pairs", cell0, T6_N);
    check_eq("t6_pairs_n_gt_h", gt_h, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end
endmodule
